// File: rtl/lfsr5_prbs_checker.sv
// lfsr5_prbs_checker: self-synchronising checker for the serial x^5+x^3+1 PRBS.
// Optional macro LFSR5_CHK_CLR_EN adds the err_clr input that clears err_cnt.
module lfsr5_prbs_checker #(
    parameter int LOCK_CNT  = 8,
    parameter int WIN_LEN   = 31,
    parameter int ERR_LIMIT = 4,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst_b,
`ifdef LFSR5_CHK_CLR_EN
    input  logic             err_clr,
`endif
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {HUNT = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10} state_t;

    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [15:0] WIN_LAST  = 16'(WIN_LEN - 1);
    localparam logic [15:0] ERR_LAST  = 16'(ERR_LIMIT - 1);

    state_t           state;
    logic [4:0]       sr;
    logic [2:0]       fill;
    logic [7:0]       match;
    logic [15:0]      win;
    logic [15:0]      werr;
    logic             p;
    logic             mis;
    logic             clr;
    logic             bump;
    logic [4:0]       sr_nxt;
    logic [ERR_W-1:0] cnt_base;
    logic [ERR_W-1:0] cnt_inc;

    // Prediction, next shift value and error-counter update; a clear applies before the increment
    always_comb begin
        p        = sr[2] ^ sr[4];
        mis      = in_bit ^ p;
        sr_nxt   = {sr[3:0], (state == LOCKED) ? p : in_bit};
`ifdef LFSR5_CHK_CLR_EN
        clr      = err_clr;
`else
        clr      = 1'b0;
`endif
        bump     = in_valid && state == LOCKED && mis;
        cnt_base = clr ? '0 : err_cnt;
        cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + ERR_W'(1);
    end

    // Hunt / verify / locked sequencing with window-based error density tracking
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= HUNT;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            win       <= '0;
            werr      <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= bump;
            err_cnt   <= bump ? cnt_inc : cnt_base;
            if (in_valid) begin
                sr <= sr_nxt;
                case (state)
                    HUNT: begin
                        fill <= (fill == 3'd5) ? fill : fill + 3'd1;
                        if (fill >= 3'd4 && sr_nxt != '0) begin
                            state <= VERIFY;
                            match <= '0;
                        end
                    end
                    VERIFY: begin
                        if (mis) begin
                            state <= HUNT;
                            fill  <= '0;
                        end else if (match == LOCK_LAST) begin
                            state <= LOCKED;
                            win   <= '0;
                            werr  <= '0;
                        end else begin
                            match <= match + 8'd1;
                        end
                    end
                    LOCKED: begin
                        win <= (win == WIN_LAST) ? '0 : win + 16'd1;
                        if (mis && werr == ERR_LAST) begin
                            state <= HUNT;
                            fill  <= '0;
                        end else if (win == WIN_LAST) begin
                            werr <= '0;
                        end else if (mis) begin
                            werr <= werr + 16'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign locked  = (state == LOCKED);
    assign state_o = state;
endmodule

// File: tb/tb_lfsr5_prbs_checker.sv
// tb_lfsr5_prbs_checker: randomized and directed bench with a sequence-table reference model.
module tb_lfsr5_prbs_checker;
    localparam int LOCK_CNT  = 8;
    localparam int WIN_LEN   = 31;
    localparam int ERR_LIMIT = 4;

    logic        clk = 0, rst_b = 0, in_valid = 0, in_bit = 0, err_clr = 0;
    logic        locked, err_pulse, locked2, err_pulse2;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2, state_o, state2;
    int          tests = 0, fails = 0, pulses = 0, g = 0;
    bit          seq[31];

    int m_state = 0, m_pos = 0, m_match = 0, m_wbits = 0, m_werr = 0, m_cnt = 0;
    bit m_pulse = 0;
    bit hist[$];

    always #5 clk = ~clk;

    lfsr5_prbs_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_LIMIT(ERR_LIMIT), .ERR_W(16)) dut (
        .clk(clk), .rst_b(rst_b),
`ifdef LFSR5_CHK_CLR_EN
        .err_clr(err_clr),
`endif
        .in_valid(in_valid), .in_bit(in_bit), .locked(locked), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .state_o(state_o));

    lfsr5_prbs_checker #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_LIMIT(ERR_LIMIT), .ERR_W(2)) dut2 (
        .clk(clk), .rst_b(rst_b),
`ifdef LFSR5_CHK_CLR_EN
        .err_clr(err_clr),
`endif
        .in_valid(in_valid), .in_bit(in_bit), .locked(locked2), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2), .state_o(state2));

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    // Position in the 31-bit period of the newest history bit, found by table search
    function automatic int find_pos();
        for (int k = 0; k < 31; k++) begin
            bit ok;
            ok = 1;
            for (int i = 0; i < 5; i++) if (seq[(k + i) % 31] != hist[i]) ok = 0;
            if (ok) return (k + 4) % 31;
        end
        return 0;
    endfunction

    function automatic bit hist_nonzero();
        int ones;
        ones = 0;
        foreach (hist[i]) ones += int'(hist[i]);
        return ones != 0;
    endfunction

    // Reference model: HUNT keeps the last 5 bits, VERIFY/LOCKED predict from the sequence table
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_state = 0; m_cnt = 0; m_pulse = 0; m_match = 0; m_wbits = 0; m_werr = 0;
            hist.delete();
        end else begin
            m_pulse = 0;
`ifdef LFSR5_CHK_CLR_EN
            if (err_clr) m_cnt = 0;
`endif
            if (in_valid) begin
                if (m_state == 0) begin
                    hist.push_back(in_bit);
                    if (hist.size() > 5) void'(hist.pop_front());
                    if (hist.size() == 5 && hist_nonzero()) begin
                        m_state = 1;
                        m_match = 0;
                    end
                end else if (m_state == 1) begin
                    if (in_bit != seq[(find_pos() + 1) % 31]) begin
                        m_state = 0;
                        hist.delete();
                    end else begin
                        hist.push_back(in_bit);
                        void'(hist.pop_front());
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_state = 2; m_pos = find_pos(); m_wbits = 0; m_werr = 0;
                        end
                    end
                end else begin
                    m_pos = (m_pos + 1) % 31;
                    if (in_bit != seq[m_pos]) begin
                        m_pulse = 1;
                        if (m_cnt < 65535) m_cnt++;
                        m_werr++;
                    end
                    m_wbits++;
                    if (m_werr >= ERR_LIMIT) begin
                        m_state = 0;
                        hist.delete();
                    end else if (m_wbits == WIN_LEN) begin
                        m_wbits = 0;
                        m_werr = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("state_o", int'(state_o), m_state);
        chk("locked", int'(locked), int'(m_state == 2));
        chk("err_pulse", int'(err_pulse), int'(m_pulse));
        chk("err_cnt", int'(err_cnt), m_cnt);
        chk("err_cnt_sat2", int'(err_cnt2), (m_cnt > 3) ? 3 : m_cnt);
    end

    task automatic tx(input bit v, input bit flip);
        in_valid = v;
        in_bit = v ? (seq[g] ^ flip) : 1'($urandom_range(0, 1));
        if (v) g = (g + 1) % 31;
        @(posedge clk);
        #1;
        pulses += int'(err_pulse);
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst_b = 0;
        @(posedge clk);
        #1;
        rst_b = 1;
    endtask

    task automatic lock_fresh();
        do_reset();
        g = 0;
        repeat (13) tx(1, 0);
        chk("lock_fresh", int'(locked), 1);
    endtask

    initial begin
        seq[0] = 1; seq[1] = 0; seq[2] = 0; seq[3] = 0; seq[4] = 0;
        for (int n = 5; n < 31; n++) seq[n] = seq[n - 3] ^ seq[n - 5];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        rst_b = 1;
        g = 0;
        for (int i = 1; i <= 200; i++) begin
            tx(1, 0);
            if (i == 4) chk("hunt_bit4", int'(state_o), 0);
            if (i == 5) chk("verify_bit5", int'(state_o), 1);
            if (i == 12) chk("unlocked_bit12", int'(locked), 0);
            if (i == 13) chk("locked_bit13", int'(locked), 1);
        end
        chk("clean_err_cnt", int'(err_cnt), 0);

        lock_fresh();
        pulses = 0;
        for (int i = 1; i <= 100; i++) begin
            tx(1, i == 40);
            if (i == 40) chk("single_pulse", int'(err_pulse), 1);
        end
        chk("single_pulse_count", pulses, 1);
        chk("single_err_cnt", int'(err_cnt), 1);
        chk("single_locked", int'(locked), 1);

        lock_fresh();
        for (int i = 1; i <= 8; i++) begin
            tx(1, i >= 5);
            if (i == 7) chk("loss_still_locked", int'(state_o), 2);
        end
        chk("loss_state", int'(state_o), 0);
        chk("loss_err_cnt", int'(err_cnt), 4);
        for (int j = 1; j <= 13; j++) begin
            tx(1, 0);
            if (j == 12) chk("relock_early", int'(locked), 0);
            if (j == 13) chk("relock", int'(locked), 1);
        end

        lock_fresh();
        for (int i = 1; i <= 70; i++) tx(1, i inside {3, 11, 31, 32, 41, 51});
        chk("wrap_locked", int'(locked), 1);
        chk("wrap_err_cnt", int'(err_cnt), 6);

        lock_fresh();
        for (int i = 1; i <= 31; i++) tx(1, i inside {1, 2, 3, 31});
        chk("loss_at_wrap", int'(state_o), 0);

        do_reset();
        in_valid = 1;
        in_bit = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("zeros_hunt", int'(state_o), 0);
        do_reset();
        g = 0;
        for (int nv = 1; nv <= 13; nv++) begin
            tx(1, 0);
            if (nv == 12) chk("gap_unlocked", int'(locked), 0);
            if (nv == 13) chk("gap_locked", int'(locked), 1);
            tx(0, 0);
        end

        lock_fresh();
        for (int i = 1; i <= 25; i++) tx(1, i inside {3, 11, 21});
        chk("pre_rst_err_cnt", int'(err_cnt), 3);
        rst_b = 0;
        #1;
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_err_cnt", int'(err_cnt), 0);
        @(posedge clk);
        #1;
        rst_b = 1;

`ifdef LFSR5_CHK_CLR_EN
        lock_fresh();
        for (int i = 1; i <= 10; i++) tx(1, i == 3);
        chk("clr_pre", int'(err_cnt), 1);
        err_clr = 1;
        tx(1, 0);
        err_clr = 0;
        chk("clr_cnt", int'(err_cnt), 0);
        chk("clr_locked", int'(locked), 1);
        err_clr = 1;
        tx(1, 1);
        err_clr = 0;
        chk("clr_and_err", int'(err_cnt), 1);
`endif

        lock_fresh();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r == 0) do_reset();
            if (r >= 990) g = int'($urandom_range(0, 30));
`ifdef LFSR5_CHK_CLR_EN
            err_clr = ($urandom_range(0, 99) == 0);
`endif
            tx($urandom_range(0, 99) < 80, $urandom_range(0, 39) == 0);
        end
        err_clr = 0;
        in_valid = 0;
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lfsr5_prbs_checker.md
Name: lfsr5_prbs_checker

Overview:
- Receive-side checker for the serial 5-bit maximal-length PRBS produced by the team's 5-bit LFSR generators.
- Self-synchronises to an incoming bit stream, confirms lock, then predicts each bit, flags mismatches and counts them.
- Drops lock and re-hunts when the error density exceeds a limit.
- Sits at the sink end of a PRBS link-test path, clocked in the same domain as the data.

Parameters:
LOCK_CNT, 8, consecutive correct predictions required in VERIFY before lock (1..255)
WIN_LEN, 31, valid bits per error-density window while locked (2..65535)
ERR_LIMIT, 4, errors within one window that force loss of lock (1..WIN_LEN)
ERR_W, 16, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_b  input  1  asynchronous active-low reset
in_valid  input  1  in_bit is sampled on this cycle; when low, all state holds
in_bit  input  1  received serial PRBS bit
locked  output  1  high while in LOCKED state
err_pulse  output  1  one-cycle pulse, registered, for each mismatch detected while LOCKED
err_cnt  output  ERR_W  total mismatches while LOCKED; saturates at all-ones
state_o  output  2  current state: 00 HUNT, 01 VERIFY, 10 LOCKED

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_b is asynchronous and active-low.
- Reset: state HUNT; shift register sr[4:0], fill count, match count, window and window-error counters all 0. Outputs locked=0, err_pulse=0, err_cnt=0, state_o=00.
- Sequence definition: s[n] = s[n-3] XOR s[n-5] (x^5+x^3+1, period 31). sr[0] holds the newest bit. Predicted bit p = sr[2] XOR sr[4].
- HUNT:
  - Each valid bit shifts into sr; fill count saturates at 5.
  - When fill reaches 5 (including the bit just shifted in) and sr != 0, go to VERIFY with match count 0.
  - An all-zero sr stays in HUNT, sliding on each further valid bit.
- VERIFY:
  - Each valid bit compares in_bit with p, then shifts in_bit into sr.
  - Match: match count +1. At LOCK_CNT matches, go to LOCKED.
  - Mismatch: go to HUNT, fill count 0. err_cnt is unchanged and no err_pulse is raised.
- LOCKED:
  - Each valid bit shifts p, not in_bit, into sr, so a single bit error does not propagate.
  - Mismatch: err_pulse=1 on the next cycle, err_cnt +1 (saturating), window errors +1.
  - Window counter runs 0..WIN_LEN-1; on wrap, window errors clear to 0.
  - When window errors reach ERR_LIMIT: go to HUNT, fill count 0. err_cnt is retained.
  - Loss of lock takes priority over a window wrap in the same cycle.
- Latency: a state change and locked are visible one cycle after the deciding valid bit. Lock is reached after 5 + LOCK_CNT valid bits of clean data.
- in_valid=0: no shifting, no comparison, err_pulse=0.
- Reset asserted mid-operation: immediate return to the reset values above, including err_cnt.

Optional Feature:
- Macro: LFSR5_CHK_CLR_EN.
- Defined: adds input port err_clr (1 bit, synchronous, active-high). When high, err_cnt clears to 0 on the next edge. If a mismatch occurs in the same cycle, err_cnt = 1 (the clear applies first, then the increment). State and window counters are unaffected.
- Not defined: no err_clr port; err_cnt clears only on reset.

Test Plan:
- Clean lock: generator seeded s[0..4]=1,0,0,0,0, in_valid=1 continuously -> state_o goes 00→01 after bit 5, locked=1 one cycle after bit 13, err_cnt=0 over 200 bits.
- Single error: once locked, flip bit 40 -> exactly one err_pulse one cycle later, err_cnt=1, locked stays 1, no further pulses over 100 bits.
- Loss of lock: once locked, flip 4 bits within one 31-bit window -> err_cnt=4, state_o returns 00 one cycle after the 4th flip, then relocks 13 valid bits later.
- Window wrap: 3 flips in window k and 3 flips in window k+1 (ERR_LIMIT=4) -> locked stays 1, err_cnt=6.
- Idle and all-zero input: 20 zero bits -> remains HUNT. Then the generator stream with in_valid toggling 1/0 -> lock after 13 valid bits regardless of gaps.
- Reset mid-lock: rst_b low for 1 cycle while err_cnt=3 -> outputs immediately 0, state_o=00. With LFSR5_CHK_CLR_EN: err_clr pulse -> err_cnt=0 while locked stays 1.
